// File: rtl/core_dffr_pkg.sv
// Shared mode encoding and helpers for the configurable set/reset register pipe.
package core_dffr_pkg;

  typedef enum logic [1:0] {
    CBIT_GCLR = 2'b00,
    CBIT_GSET = 2'b01,
    CBIT_FCLR = 2'b10,
    CBIT_FSET = 2'b11
  } cbit_e;

  function automatic logic is_forced(input cbit_e mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/core_dffr_stage.sv
// One pipeline stage: WIDTH-bit data register plus valid tag.
// Priority is power-up reset, then clear-to-value, then load, then hold.
module core_dffr_stage #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             purst,
  input  logic             ld,
  input  logic             clr,
  input  logic [WIDTH-1:0] clr_val,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (clr) begin
      data_d = clr_val;
      vld_d  = 1'b0;
    end else if (ld) begin
      data_d = d;
      vld_d  = d_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (purst) begin
      data_q <= INIT;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q     = data_q;
  assign q_vld = vld_q;

endmodule

// File: rtl/core_dffr_pipe.sv
// WIDTH x DEPTH register pipe with clock enable, valid tag and a registered
// set/reset mode that selects gated or forced clear/set of every stage.
module core_dffr_pipe
  import core_dffr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] INIT    = '0,
  parameter logic [WIDTH-1:0] SET_VAL = '1
) (
  input  logic             clk,
  input  logic             purst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  input  logic             S_R,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_cbit,
  output logic [1:0]       cbit,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
);

  cbit_e mode_q;

  always_ff @(posedge clk) begin
    if (purst)       mode_q <= CBIT_GCLR;
    else if (cfg_we) mode_q <= cbit_e'(cfg_cbit);
  end

  assign cbit = mode_q;

  // An unknown mode falls to the default arm: S_R does nothing, shift proceeds.
  logic sr_act, sr_set;
  always_comb begin
    sr_act = 1'b0;
    sr_set = 1'b0;
    case (mode_q)
      CBIT_GCLR, CBIT_GSET, CBIT_FCLR, CBIT_FSET: begin
        sr_act = S_R & (is_forced(mode_q) | ce);
        sr_set = mode_q[0];
      end
      default: ;
    endcase
  end

  logic             ld;
  logic [WIDTH-1:0] clr_val;
  assign ld      = ce & ~sr_act;
  assign clr_val = sr_set ? SET_VAL : '0;

  logic [DEPTH-1:0][WIDTH-1:0] stg_q;
  logic [DEPTH-1:0]            vld_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] din;
    logic             din_vld;
    if (i == 0) begin : g_head
      assign din     = d;
      assign din_vld = d_vld;
    end else begin : g_body
      assign din     = stg_q[i-1];
      assign din_vld = vld_q[i-1];
    end

    core_dffr_stage #(.WIDTH(WIDTH), .INIT(INIT)) u_stage (
      .clk     (clk),
      .purst   (purst),
      .ld      (ld),
      .clr     (sr_act),
      .clr_val (clr_val),
      .d       (din),
      .d_vld   (din_vld),
      .q       (stg_q[i]),
      .q_vld   (vld_q[i])
    );
  end

  assign q     = stg_q[DEPTH-1];
  assign q_vld = vld_q[DEPTH-1];

endmodule

// File: tb/tb_core_dffr_pipe.sv
// Scoreboard bench for core_dffr_pipe: a queue-based pipe model produces the
// expected q/q_vld/cbit after every edge; a negedge monitor pops and compares.
module tb_core_dffr_pipe;

  localparam int         WIDTH   = 8;
  localparam int         DEPTH   = 2;
  localparam logic [7:0] INIT    = 8'h5A;
  localparam logic [7:0] SET_VAL = 8'hFF;

  logic             clk = 1'b0;
  logic             purst, ce, d_vld, S_R, cfg_we;
  logic [WIDTH-1:0] d;
  logic [1:0]       cfg_cbit, cbit;
  logic [WIDTH-1:0] q;
  logic             q_vld;

  core_dffr_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT(INIT), .SET_VAL(SET_VAL)) dut (
    .clk(clk), .purst(purst), .ce(ce), .d(d), .d_vld(d_vld), .S_R(S_R),
    .cfg_we(cfg_we), .cfg_cbit(cfg_cbit), .cbit(cbit), .q(q), .q_vld(q_vld)
  );

  always #5 clk = ~clk;

  typedef struct { logic [WIDTH-1:0] data; logic vld; } ent_t;
  typedef struct { logic [WIDTH-1:0] q; logic vld; logic [1:0] cbit; } exp_t;

  ent_t pipe[$];      // pipe[0] is the youngest word, pipe[DEPTH-1] drives q
  logic [1:0] m_mode;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic fill(input logic [WIDTH-1:0] v);
    ent_t e;
    pipe.delete();
    e.data = v; e.vld = 1'b0;
    for (int i = 0; i < DEPTH; i++) pipe.push_back(e);
  endtask

  // Model of one edge, from the behavioural rules only.
  task automatic model_edge(input logic p, input logic c, input logic [WIDTH-1:0] dd,
                            input logic dv, input logic sr, input logic we, input logic [1:0] cb);
    logic act;
    ent_t e;
    if (p) begin
      fill(INIT);
      m_mode = 2'b00;
      return;
    end
    act = sr && (m_mode[1] || c);
    if (act) fill(m_mode[0] ? SET_VAL : '0);
    else if (c) begin
      e.data = dd; e.vld = dv;
      pipe.push_front(e);
      void'(pipe.pop_back());
    end
    if (we) m_mode = cb;
  endtask

  task automatic drive(input logic p, input logic c, input logic [WIDTH-1:0] dd,
                       input logic dv, input logic sr, input logic we, input logic [1:0] cb);
    exp_t x;
    purst = p; ce = c; d = dd; d_vld = dv; S_R = sr; cfg_we = we; cfg_cbit = cb;
    model_edge(p, c, dd, dv, sr, we, cb);
    @(posedge clk);
    x.q = pipe[DEPTH-1].data; x.vld = pipe[DEPTH-1].vld; x.cbit = m_mode;
    sb.push_back(x);
    #2;
  endtask

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp += 3;
      if (q !== e.q)       begin n_bad++; $display("FAIL sb_q: got %h expected %h", q, e.q); end
      if (q_vld !== e.vld) begin n_bad++; $display("FAIL sb_vld: got %b expected %b", q_vld, e.vld); end
      if (cbit !== e.cbit) begin n_bad++; $display("FAIL sb_cbit: got %b expected %b", cbit, e.cbit); end
    end
  end

  initial begin
    purst = 1'b1; ce = 0; d = '0; d_vld = 0; S_R = 0; cfg_we = 0; cfg_cbit = '0;
    fill(INIT); m_mode = 2'b00;
    @(negedge clk);

    // reset
    drive(1, 0, 8'h00, 0, 0, 0, 2'b00);
    chk("rst_q", q, INIT); chk("rst_vld", {7'd0, q_vld}, 8'd0); chk("rst_cbit", {6'd0, cbit}, 8'd0);

    // latency with stalls
    drive(0, 1, 8'h11, 1, 0, 0, 2'b00);
    chk("lat_e1_vld", {7'd0, q_vld}, 8'd0);
    drive(0, 1, 8'h22, 1, 0, 0, 2'b00);
    chk("lat_e2_q", q, 8'h11); chk("lat_e2_vld", {7'd0, q_vld}, 8'd1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'h99, 1, 0, 0, 2'b00);
      chk("lat_stall_q", q, 8'h11);
    end
    drive(0, 1, 8'h00, 0, 0, 0, 2'b00);
    chk("lat_e3_q", q, 8'h22); chk("lat_e3_vld", {7'd0, q_vld}, 8'd1);

    // gated vs forced
    drive(0, 0, 8'h00, 0, 0, 1, 2'b01);
    drive(0, 0, 8'h00, 0, 1, 0, 2'b00);
    chk("gset_hold_q", q, 8'h22);
    drive(0, 0, 8'h00, 0, 0, 1, 2'b11);
    drive(0, 0, 8'h00, 0, 1, 0, 2'b00);
    chk("fset_q", q, 8'hFF); chk("fset_vld", {7'd0, q_vld}, 8'd0);

    // mode change timing: clear uses old mode 00 (ce=1)
    drive(0, 1, 8'h33, 1, 0, 1, 2'b00);
    drive(0, 1, 8'h34, 1, 0, 0, 2'b00);
    drive(0, 1, 8'h35, 1, 1, 1, 2'b10);
    chk("mchg_q", q, 8'h00); chk("mchg_cbit", {6'd0, cbit}, 8'd2);
    drive(0, 0, 8'h36, 1, 1, 0, 2'b00);
    chk("fclr_q", q, 8'h00);

    // flush and restart
    drive(0, 1, 8'h01, 1, 0, 1, 2'b00);
    drive(0, 1, 8'h02, 1, 0, 0, 2'b00);
    drive(0, 1, 8'h03, 1, 0, 0, 2'b00);
    drive(0, 1, 8'h04, 1, 0, 0, 2'b00);
    drive(0, 1, 8'hEE, 1, 1, 0, 2'b00);
    chk("flush_q", q, 8'h00); chk("flush_vld", {7'd0, q_vld}, 8'd0);
    drive(0, 1, 8'hA5, 1, 0, 0, 2'b00);
    chk("restart_e1_vld", {7'd0, q_vld}, 8'd0);
    drive(0, 1, 8'h00, 0, 0, 0, 2'b00);
    chk("restart_q", q, 8'hA5); chk("restart_vld", {7'd0, q_vld}, 8'd1);

    // purst beats forced set
    drive(0, 0, 8'h00, 0, 0, 1, 2'b11);
    drive(1, 0, 8'h00, 0, 1, 1, 2'b11);
    chk("prst_q", q, INIT); chk("prst_cbit", {6'd0, cbit}, 8'd0);
    drive(0, 0, 8'h00, 0, 1, 0, 2'b00);
    chk("prst_after_q", q, INIT);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(49) == 0), ($urandom_range(9) < 7), 8'($urandom),
            1'($urandom), ($urandom_range(99) < 15), ($urandom_range(9) == 0), 2'($urandom));

    begin : drain
      int budget = 10;
      while (sb.size() > 0 && budget > 0) begin @(posedge clk); budget--; end
      if (sb.size() > 0) begin
        n_cmp++; n_bad++;
        $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
